// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store initiator for memory port B.
// A request is accepted in IDLE, presented to the memory for one ISSUE
// cycle, optionally waits out the remaining memory latency, and is then
// returned over a valid/ready response channel.
// Optional feature macro: MEM_LSU_WRITE_PROTECT_EN. When it is defined,
// stores below PROT_LIMIT are turned into reads and flagged with resp_err.
module mem_lsu #(
  parameter int WIDTH       = 16,
  parameter int MEM_LATENCY = 1,
  parameter int PROT_LIMIT  = 16'h0100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             busy,
  output logic             we_b,
  output logic [WIDTH-1:0] addr_b,
  output logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] q_b
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  state_t     state_next;
  // Remaining posedges before q_b is valid; MEM_LATENCY is at most 4.
  logic [1:0] count;
  logic       prot_hit;
  logic       capture;

  // The ISSUE edge samples directly when latency is 1; otherwise WAIT
  // samples on the edge where the counter reads 1.
  assign capture = ((state == ISSUE) && (count == 2'd0)) ||
                   ((state == WAIT)  && (count == 2'd1));

`ifdef MEM_LSU_WRITE_PROTECT_EN
  localparam logic [WIDTH-1:0] PROT_LIM = WIDTH'(PROT_LIMIT);
  logic prot_reg;

  // Stores into the protected low region never raise we_b.
  assign prot_hit = req_we && (req_addr < PROT_LIM);

  // Remember the protection verdict of the accepted request and report it with the response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prot_reg <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      if ((state == IDLE) && req_valid) prot_reg <= prot_hit;
      if (capture) resp_err <= prot_reg;
      else if ((state == RESP) && resp_ready) resp_err <= 1'b0;
    end
  end
`else
  assign prot_hit = 1'b0;
  assign resp_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = ISSUE;
      ISSUE:   state_next = (count == 2'd0) ? RESP : WAIT;
      WAIT:    if (count == 2'd1) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  // Memory port drive, latency counter and response capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_b       <= 1'b0;
      addr_b     <= '0;
      data_b     <= '0;
      count      <= 2'd0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_b <= req_addr;
            data_b <= req_wdata;
            we_b   <= req_we && !prot_hit;
            count  <= 2'(MEM_LATENCY - 1);
          end
        end
        ISSUE: begin
          we_b <= 1'b0;
        end
        WAIT: begin
          count <= count - 2'd1;
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: we_b <= 1'b0;
      endcase
      if (capture) begin
        resp_rdata <= q_b;
        resp_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed scoreboard bench for mem_lsu. Instance 0 runs with
// MEM_LATENCY=1, instance 1 with MEM_LATENCY=3; each has its own port-B
// memory model that acts on the negedge.
module tb_mem_lsu;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          we_cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [15:0] req_addr   [2];
  logic [15:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [15:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        busy       [2];
  logic        we_b       [2];
  logic [15:0] addr_b     [2];
  logic [15:0] data_b     [2];
  logic [15:0] q_b0;
  logic [15:0] q_b1;

  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];
  logic        pl_en [2];
  logic [15:0] pl_addr;
  logic [15:0] pl_data;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  mem_lsu #(.WIDTH(16), .MEM_LATENCY(1), .PROT_LIMIT(16'h0100)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0]),
    .we_b(we_b[0]), .addr_b(addr_b[0]), .data_b(data_b[0]), .q_b(q_b0)
  );

  mem_lsu #(.WIDTH(16), .MEM_LATENCY(3), .PROT_LIMIT(16'h0100)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1]),
    .we_b(we_b[1]), .addr_b(addr_b[1]), .data_b(data_b[1]), .q_b(q_b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Port-B memory for instance 0: write echoes data on q_b, read returns content.
  always @(negedge clk) begin
    if (pl_en[0]) mem_a[pl_addr] <= pl_data;
    else if (we_b[0]) begin
      mem_a[addr_b[0]] <= data_b[0];
      q_b0 <= data_b[0];
    end else q_b0 <= mem_a[addr_b[0]];
  end

  // Port-B memory for instance 1.
  always @(negedge clk) begin
    if (pl_en[1]) mem_b[pl_addr] <= pl_data;
    else if (we_b[1]) begin
      mem_b[addr_b[1]] <= data_b[1];
      q_b1 <= data_b[1];
    end else q_b1 <= mem_b[addr_b[1]];
  end

  initial begin
    #200000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  task automatic preload(input int k, input logic [15:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en[k] = 1'b1;
    @(negedge clk);
    #1;
    pl_en[k] = 1'b0;
  endtask

  // Wait for the response, check latency and scoreboard entry, apply
  // 'hold' cycles of backpressure, then complete the handshake.
  task automatic collect(input int k, input int acc, input int we0,
                         input logic [15:0] addr, input int hold);
    exp_t        e;
    int          n;
    int          wecnt;
    logic [15:0] held;
    wecnt = we0;
    n = 0;
    while (!resp_valid[k] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      wecnt += int'(we_b[k]);
    end
    chk("latency", 32'(cyc - acc), (k == 0) ? 32'd1 : 32'd3);
    e = sb.pop_front();
    chk("rdata", {16'h0, resp_rdata[k]}, {16'h0, e.data});
    chk("err", {31'h0, resp_err[k]}, {31'h0, e.err});
    chk("we_cycles", 32'(wecnt), 32'(e.we_cnt));
    held = resp_rdata[k];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'h0, resp_valid[k]}, 32'd1);
      chk("hold_rdata", {16'h0, resp_rdata[k]}, {16'h0, held});
      chk("hold_ready", {31'h0, req_ready[k]}, 32'd0);
    end
    resp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[k] = 1'b0;
    chk("done_valid", {31'h0, resp_valid[k]}, 32'd0);
    chk("done_ready", {31'h0, req_ready[k]}, 32'd1);
    chk("done_addr_b", {16'h0, addr_b[k]}, {16'h0, addr});
    chk("done_we_b", {31'h0, we_b[k]}, 32'd0);
    $display("txn inst=%0d addr=%h rdata=%h err=%0d lat=%0d", k, addr, held, resp_err[k], cyc - acc - hold - 1);
  endtask

  task automatic txn(input int k, input logic we, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic [15:0] exp_data,
                     input logic exp_err, input int exp_we, input int hold,
                     input bit early);
    exp_t e;
    int   n;
    int   acc;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    if (early) resp_ready[k] = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid[k] = 1'b0;
    req_addr[k]  = 16'($urandom);
    req_wdata[k] = 16'($urandom);
    e.data = exp_data;
    e.err = exp_err;
    e.we_cnt = exp_we;
    sb.push_back(e);
    chk("accept_busy", {31'h0, busy[k]}, 32'd1);
    collect(k, acc, int'(we_b[k]), addr, hold);
  endtask

  initial begin
    int          acc;
    exp_t        e;
    logic [15:0] prot_data;
    logic        prot_err;
    int          prot_we;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; resp_ready[k] = 1'b0; pl_en[k] = 1'b0;
    end
    pl_addr = '0;
    pl_data = '0;

    preload(0, 16'h0010, 16'h0042);
    preload(0, 16'h0000, 16'h5A5A);
    preload(0, 16'h0300, 16'h1234);
    preload(1, 16'h0300, 16'h1234);

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_ready", {31'h0, req_ready[0]}, 32'd1);
    chk("rst_busy", {31'h0, busy[0]}, 32'd0);
    chk("rst_we_b", {31'h0, we_b[0]}, 32'd0);
    chk("rst_valid", {31'h0, resp_valid[0]}, 32'd0);
    chk("rst_err", {31'h0, resp_err[0]}, 32'd0);

    // Reset during ISSUE discards the store
    @(posedge clk);
    #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'h0500; req_wdata[0] = 16'h9999;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    chk("issue_we_b", {31'h0, we_b[0]}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async_we_b", {31'h0, we_b[0]}, 32'd0);
    chk("async_busy", {31'h0, busy[0]}, 32'd0);
    chk("async_addr_b", {16'h0, addr_b[0]}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("no_resp_after_rst", {31'h0, resp_valid[0]}, 32'd0);
    end
    chk("ready_after_rst", {31'h0, req_ready[0]}, 32'd1);

    // Store then load at 0x0200
    txn(0, 1'b1, 16'h0200, 16'hBEEF, 16'hBEEF, 1'b0, 1, 0, 1'b0);
    txn(0, 1'b0, 16'h0200, 16'h0000, 16'hBEEF, 1'b0, 0, 0, 1'b1);

    // Latency 3 and latency 1 loads of a preloaded word
    txn(1, 1'b0, 16'h0300, 16'h0000, 16'h1234, 1'b0, 0, 0, 1'b0);
    txn(0, 1'b0, 16'h0300, 16'h0000, 16'h1234, 1'b0, 0, 0, 1'b0);

    // Backpressure with a pending second request
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 16'h0200;
    @(posedge clk);
    #1;
    acc = cyc;
    e.data = 16'hBEEF; e.err = 1'b0; e.we_cnt = 0;
    sb.push_back(e);
    req_we[0] = 1'b1; req_addr[0] = 16'h0400; req_wdata[0] = 16'h1111;
    collect(0, acc, int'(we_b[0]), 16'h0200, 5);
    chk("pending_not_taken", {31'h0, busy[0]}, 32'd0);
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid[0] = 1'b0;
    chk("pending_accept_we_b", {31'h0, we_b[0]}, 32'd1);
    chk("pending_accept_addr", {16'h0, addr_b[0]}, 32'h0400);
    e.data = 16'h1111; e.err = 1'b0; e.we_cnt = 1;
    sb.push_back(e);
    collect(0, acc, int'(we_b[0]), 16'h0400, 0);

    // Top and bottom of the address range
    txn(0, 1'b1, 16'hFFFF, 16'hA5A5, 16'hA5A5, 1'b0, 1, 0, 1'b0);
    txn(0, 1'b0, 16'hFFFF, 16'h0000, 16'hA5A5, 1'b0, 0, 0, 1'b0);
    txn(1, 1'b1, 16'hFFFF, 16'h5AA5, 16'h5AA5, 1'b0, 1, 2, 1'b0);
    txn(1, 1'b0, 16'hFFFF, 16'h0000, 16'h5AA5, 1'b0, 0, 0, 1'b0);
`ifdef MEM_LSU_WRITE_PROTECT_EN
    txn(0, 1'b1, 16'h0000, 16'h3C3C, 16'h5A5A, 1'b1, 0, 0, 1'b0);
    prot_data = 16'h0042; prot_err = 1'b1; prot_we = 0;
`else
    txn(0, 1'b1, 16'h0000, 16'h3C3C, 16'h3C3C, 1'b0, 1, 0, 1'b0);
    prot_data = 16'hDEAD; prot_err = 1'b0; prot_we = 1;
`endif

    // Protected region store, first writable address, read-back
    txn(0, 1'b1, 16'h0010, 16'hDEAD, prot_data, prot_err, prot_we, 0, 1'b0);
    txn(0, 1'b1, 16'h0100, 16'h7777, 16'h7777, 1'b0, 1, 0, 1'b0);
    txn(0, 1'b0, 16'h0010, 16'h0000, prot_data, 1'b0, 0, 0, 1'b0);
    txn(0, 1'b0, 16'h0100, 16'h0000, 16'h7777, 1'b0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
